// File: rtl/approx_mult_error_monitor.sv
// Error-statistics collector for unsigned approximate multipliers.
// Compares z_approx against the exact x*y over a programmed window.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   start             one-cycle pulse, opens a window (ignored when busy)
//   num_samples       window length, latched on an accepted start
//   in_valid/in_ready sample handshake (x, y, z_approx)
//   busy              high from accepted start through the done cycle
//   done              one-cycle pulse, results are final
//   err_count         samples with z_approx != x*y
//   sum_ed            sum of |x*y - z_approx|
//   max_ed            largest |x*y - z_approx| seen
module approx_mult_error_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_samples,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         x,
    input  logic [WIDTH-1:0]         y,
    input  logic [2*WIDTH-1:0]       z_approx,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         err_count,
    output logic [2*WIDTH+CNT_W-1:0] sum_ed,
    output logic [2*WIDTH-1:0]       max_ed
);

    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = PW + CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] cnt_inc;

    logic          s1_valid;
    logic [PW-1:0] s1_p;
    logic [PW-1:0] s1_z;
    logic          s2_valid;
    logic [PW-1:0] s2_ed;
    logic [PW-1:0] ed_c;

    logic accept;
    logic last;
    logic win_open;
    logic clear;

    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt_q + 1'b1;
    assign last     = accept && (cnt_inc == n_q);
    assign win_open = (state_q == IDLE) && start;
    // Results are cleared on every accepted start, including empty windows.
    assign clear    = win_open;

    // Absolute difference; both operands are unsigned PW-bit values.
    assign ed_c = (s1_p >= s1_z) ? (s1_p - s1_z) : (s1_z - s1_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_samples != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!s1_valid && !s2_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            n_q   <= '0;
        end else if (win_open) begin
            cnt_q <= '0;
            n_q   <= num_samples;
        end else if (accept) begin
            cnt_q <= cnt_inc;
        end
    end

    // Stage 1: exact product and captured approximation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_z     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_p <= PW'(x) * PW'(y);
                s1_z <= z_approx;
            end
        end
    end

    // Stage 2: error distance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_ed    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed <= ed_c;
            end
        end
    end

    // Accumulators; clearing only happens in IDLE with an empty pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (clear) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (s2_valid) begin
            sum_ed <= sum_ed + {{CNT_W{1'b0}}, s2_ed};
            if (s2_ed != '0) begin
                err_count <= err_count + 1'b1;
            end
            if (s2_ed > max_ed) begin
                max_ed <= s2_ed;
            end
        end
    end

    logic unused_acc_w;
    assign unused_acc_w = (ACC_W == 0);

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Directed self-checking bench for approx_mult_error_monitor.
// Hand-computed windows: exact, mixed, stalls, zero, busy start, reset.
module tb_approx_mult_error_monitor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z_approx;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic [31:0] sum_ed;
    logic [15:0] max_ed;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int d0;

    approx_mult_error_monitor #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_samples(num_samples),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .z_approx   (z_approx),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count),
        .sum_ed     (sum_ed),
        .max_ed     (max_ed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic results(input string tag, input int e,
                           input int s, input int m);
        chk({tag, "_err"}, 64'(err_count), 64'(e));
        chk({tag, "_sum"}, 64'(sum_ed), 64'(s));
        chk({tag, "_max"}, 64'(max_ed), 64'(m));
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic go(input logic [15:0] n);
        start = 1'b1;
        num_samples = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] z);
        bit ok;
        ok = 0;
        x = a;
        y = b;
        z_approx = z;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        z_approx = '0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        results("rst", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Exact window
        go(16'd4);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_ready", 64'(in_ready), 64'd1);
        push(8'd3, 8'd5, 16'd15);
        push(8'd0, 8'd9, 16'd0);
        push(8'd255, 8'd255, 16'd65025);
        push(8'd16, 8'd16, 16'd256);
        chk("t1_ready_off", 64'(in_ready), 64'd0);
        wait_done("t1");
        results("t1", 0, 0, 0);
        after_done("t1");

        // Mixed errors, including z above and below the product
        go(16'd3);
        push(8'd255, 8'd255, 16'hFE00);
        push(8'd3, 8'd5, 16'd20);
        push(8'd200, 8'd100, 16'd19000);
        wait_done("t2");
        results("t2", 3, 1006, 1000);
        after_done("t2");
        results("t2_hold", 3, 1006, 1000);

        // Handshake stalls: valid on cycles 0, 4 and 9
        d0 = done_cnt;
        go(16'd2);
        push(8'd3, 8'd5, 16'd20);
        repeat (3) @(negedge clk);
        push(8'd2, 8'd2, 16'd4);
        chk("t3_ready_off", 64'(in_ready), 64'd0);
        repeat (4) @(negedge clk);
        x = 8'd10;
        y = 8'd10;
        z_approx = 16'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t3_done_once", 64'(done_cnt - d0), 64'd1);
        results("t3", 1, 5, 5);

        // Zero window clears old results and pulses done next cycle
        go(16'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_ready", 64'(in_ready), 64'd0);
        results("t4", 0, 0, 0);
        after_done("t4");

        // Start while busy is ignored
        go(16'd2);
        push(8'd255, 8'd255, 16'hFE00);
        go(16'd7);
        push(8'd200, 8'd100, 16'd19000);
        chk("t5_ready_off", 64'(in_ready), 64'd0);
        wait_done("t5");
        results("t5", 2, 1001, 1000);
        after_done("t5");

        // Reset mid-RUN
        d0 = done_cnt;
        go(16'd3);
        push(8'd3, 8'd5, 16'd20);
        repeat (2) @(negedge clk);
        results("t6_pre", 1, 5, 5);
        chk("t6_pre_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd0);
        results("t6", 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        go(16'd1);
        push(8'd16, 8'd16, 16'd250);
        wait_done("t6_fresh");
        results("t6_fresh", 1, 6, 6);
        after_done("t6_fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/approx_mult_error_monitor.md
Name: approx_mult_error_monitor

Overview:
- Sequential error-statistics collector that sits directly downstream of the unsigned 8x8 approximate multipliers.
- Each accepted sample carries the operands x, y and the approximate product z_approx.
- The block computes the exact product internally and accumulates error metrics over a programmed window:
  - number of erroneous samples
  - sum of error distances
  - maximum error distance
- Used in characterisation benches and in on-chip self-test of approximate multiplier variants.

Parameters:
- WIDTH, 8, operand width; the product is 2*WIDTH bits.
- CNT_W, 16, width of the sample counter and of num_samples.
- (local) ACC_W = 2*WIDTH+CNT_W, width of sum_ed; overflow is impossible by construction.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a measurement window
- num_samples  input  CNT_W  window length; sampled when start is accepted
- in_valid  input  1  sample valid
- in_ready  output  1  block can accept a sample
- x  input  WIDTH  multiplier operand
- y  input  WIDTH  multiplicand operand
- z_approx  input  2*WIDTH  approximate product under test
- busy  output  1  high from accepted start until the done pulse (inclusive)
- done  output  1  one-cycle pulse; all results are final
- err_count  output  CNT_W  count of samples with z_approx != x*y
- sum_ed  output  ACC_W  sum of |x*y - z_approx|
- max_ed  output  2*WIDTH  maximum |x*y - z_approx| in the window

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - in_ready, busy, done are 0.
  - err_count, sum_ed, max_ed, the internal counters and the pipeline valids are all 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - Results hold their last values.
  - start=1 with num_samples!=0:
    - clear err_count, sum_ed, max_ed;
    - load the accepted-sample counter with 0 and latch num_samples;
    - go to RUN.
  - start=1 with num_samples==0:
    - clear all results;
    - go to DONE (done pulses on the next cycle).
- RUN:
  - in_ready=1.
  - A sample is accepted when in_valid & in_ready.
  - When the accepted count reaches the latched num_samples, in_ready deasserts combinationally in that same accepting cycle's successor; the state goes to DRAIN.
  - in_valid gaps are allowed and do not advance the counter.
- DRAIN:
  - in_ready=0.
  - Stay until both pipeline valid bits are 0, then go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then go to IDLE.
- start while busy is ignored; num_samples is not re-latched.
- Pipeline (2 stages, latency 2 cycles from acceptance to the accumulator update):
  - S1 registers: exact product p = x*y, z_approx, valid.
  - S2 computes ed = (p >= z) ? p - z : z - p, as an unsigned 2*WIDTH-bit value. Then:
    - sum_ed += ed;
    - err_count += (ed != 0);
    - max_ed = max(max_ed, ed).
  - Results become final no later than the cycle done is asserted.
- Width rules:
  - Products are full 2*WIDTH unsigned.
  - sum_ed is zero-extended to ACC_W.
  - err_count ≤ num_samples ≤ 2^CNT_W - 1; no saturation logic is required.
- Reset mid-operation aborts the window immediately.
  - No done pulse is produced.
  - All outputs read 0 after reset.

Test Plan:
- Exact window: start with num_samples=4; samples (3,5,15), (0,9,0), (255,255,65025), (16,16,256) -> done after the 4th acceptance + drain; err_count=0, sum_ed=0, max_ed=0.
- Mixed errors: num_samples=3; samples (255,255,0xFE00) ED=1, (3,5,20) ED=5, (200,100,19000) ED=1000 -> err_count=3, sum_ed=1006, max_ed=1000.
- Handshake stalls: num_samples=2 with in_valid pulsed on cycles 0, 4 and 9 -> only the first two are accepted; in_ready is 0 from the cycle after the 2nd acceptance; the third sample has no effect; done fires once.
- Zero window: start with num_samples=0 -> done one cycle later; all results 0; in_ready never asserts.
- Start while busy: a second start with num_samples=7 during RUN of a 2-sample window -> ignored; the window still ends after 2 samples and results reflect those 2 only.
- Reset mid-RUN: rst asserted after 1 of 3 samples -> busy=0, in_ready=0, all results 0 immediately (asynchronously); no done; a subsequent start runs a fresh window correctly.
